call_register: RTL
==================

CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, which is the number of consecutive low samples that qualify a press (range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 button1, button2, button3  input  1 each  hall/cab buttons; active-low, idle high, asynchronous to clk.
REQ-005 floor1, floor2, floor3  input  1 each  one-hot current-floor indication from movement.
REQ-006 door  input  1  1 = door open, from movement.
REQ-007 moving  input  1  1 = car in motion, from movement.
REQ-008 led1, led2, led3  output  1 each  pending-request lamps; 1 = request latched for that floor.
REQ-009 target  output  2  floor to serve next; 0 = none, 1..3 = floor number.
REQ-010 dir_up, dir_down  output  1 each  scheduler direction; never both 1.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A press event SHALL be a single-cycle pulse on the high-to-low transition of the conditioned button level.
REQ-013 A press event on floor i SHALL set request bit i; ledi SHALL equal request bit i directly from a register.
REQ-014 Request bit i SHALL clear when floori=1, door=1 and moving=0 in the same cycle.
REQ-015 On a simultaneous set and clear of the same bit, the clear SHALL win; a press at the serviced floor with the door open is not latched.
REQ-016 A button held low SHALL produce exactly one press event; a new press requires a release of at least DEBOUNCE_CYCLES cycles (1 cycle without DEBOUNCE_EN).
REQ-017 The block SHALL track last_floor (1..3) from floor1..3; on zero-hot or multi-hot input it SHALL hold the previous value.
REQ-018 Scheduler states SHALL be IDLE, UP and DOWN; dir_up=1 only in UP, dir_down=1 only in DOWN.
REQ-019 In IDLE: any request above last_floor -> UP; else any request below -> DOWN; else stay IDLE.
REQ-020 In UP: with requests above, stay UP with target = nearest request above; with none above but some below -> DOWN; with none -> IDLE.
REQ-021 DOWN SHALL mirror REQ-020 with "below" and "above" swapped.
REQ-022 In IDLE, target SHALL equal last_floor if its request bit is set, else 0.
REQ-023 target and the state SHALL be registered and SHALL update one edge after the request bits change.
REQ-024 With DEBOUNCE_EN, ledi SHALL rise at edge 3+DEBOUNCE_CYCLES counted from the first edge that samples buttoni low; without it, at edge 3.

Reset
REQ-025 While rst_n=0 at an edge, the following SHALL be set: request bits 0, led1..3 0, target 0, state IDLE, last_floor 1, synchronizer and conditioned levels 1 (released), and debounce counters 0.
REQ-026 A button held low across reset release SHALL register as one press after the normal latency.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-028 With macro CALL_REGISTER_DEBOUNCE_EN defined, the conditioned level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-029 Without CALL_REGISTER_DEBOUNCE_EN, the conditioned level SHALL be the synchronizer output registered once, and no counters SHALL be instantiated.

Structure
REQ-030 Package elevator_pkg SHALL hold the dir_t enum (IDLE, UP, DOWN) and the constants NUM_FLOORS=3 and FLOOR_NONE=0.
REQ-031 Sub-module button_conditioner (synchronizer, optional debounce, press pulse) SHALL be instantiated once per button.

Verification
REQ-032 Reset, car at floor1, pulse button3 low for 6 cycles -> led3=1 at edge 7 (DEBOUNCE_EN, N=4), then next edge target=3 and dir_up=1.
REQ-033 button2 low for 2 cycles with DEBOUNCE_EN, N=4 -> no press event, led2 stays 0.
REQ-034 Requests at 2 and 3 in UP from floor1; floor2=1, door=1, moving=0 -> led2 clears next edge, target becomes 3, state remains UP.
REQ-035 At floor2 with door open, press button2 -> led2 never asserts; a press held 20 cycles -> exactly one press event.
REQ-036 Only request 1 pending at floor3 -> DOWN with target=1; after service -> IDLE, target=0, dir_up=0, dir_down=0.
REQ-037 rst_n low mid-debounce with button1 held low -> after release of rst_n, led1 rises at edge 3+N counted from the first edge after reset release.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared scheduler types, floor constants and small floor-mask
// helpers used by the call register and its button conditioners.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;
  localparam logic [1:0] FLOOR_NONE = 2'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  // Floor number of a one-hot floor vector; zero-hot or multi-hot keeps prev.
  function automatic logic [1:0] decode_floor(input logic [NUM_FLOORS-1:0] floors,
                                              input logic [1:0] prev);
    logic [1:0] result;
    case (floors)
      3'b001:  result = 2'd1;
      3'b010:  result = 2'd2;
      3'b100:  result = 2'd3;
      default: result = prev;
    endcase
    return result;
  endfunction

  // Lowest floor number present in a request mask, FLOOR_NONE if empty.
  function automatic logic [1:0] lowest_floor(input logic [NUM_FLOORS-1:0] mask);
    logic [1:0] result;
    if (mask[0]) begin
      result = 2'd1;
    end else if (mask[1]) begin
      result = 2'd2;
    end else if (mask[2]) begin
      result = 2'd3;
    end else begin
      result = FLOOR_NONE;
    end
    return result;
  endfunction

  // Highest floor number present in a request mask, FLOOR_NONE if empty.
  function automatic logic [1:0] highest_floor(input logic [NUM_FLOORS-1:0] mask);
    logic [1:0] result;
    if (mask[2]) begin
      result = 2'd3;
    end else if (mask[1]) begin
      result = 2'd2;
    end else if (mask[0]) begin
      result = 2'd1;
    end else begin
      result = FLOOR_NONE;
    end
    return result;
  endfunction

  // Floors strictly above the given floor.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] floor);
    logic [NUM_FLOORS-1:0] result;
    case (floor)
      2'd1:    result = 3'b110;
      2'd2:    result = 3'b100;
      2'd3:    result = 3'b000;
      default: result = 3'b110;
    endcase
    return result;
  endfunction

  // Floors strictly below the given floor.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] floor);
    logic [NUM_FLOORS-1:0] result;
    case (floor)
      2'd1:    result = 3'b000;
      2'd2:    result = 3'b001;
      2'd3:    result = 3'b011;
      default: result = 3'b000;
    endcase
    return result;
  endfunction

  // Single-bit mask selecting the given floor.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [1:0] floor);
    logic [NUM_FLOORS-1:0] result;
    case (floor)
      2'd1:    result = 3'b001;
      2'd2:    result = 3'b010;
      2'd3:    result = 3'b100;
      default: result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop synchronizer, conditioned level and a one-cycle
// press pulse on the falling edge of that level. Defining the macro
// CALL_REGISTER_DEBOUNCE_EN adds a debounce counter in front of the level.
module button_conditioner
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic level_r;
  logic level_next_s;

  if ((DEBOUNCE_CYCLES < 32'd1) || (DEBOUNCE_CYCLES > 32'd255)) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES must be within 1..255");
  end

  // Synchronizer and conditioned level; reset makes the button read as released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
      level_r <= level_next_s;
    end
  end

`ifdef CALL_REGISTER_DEBOUNCE_EN
  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [7:0] count_r;
  logic [7:0] count_next_s;

  // Count disagreeing samples; the level flips once DEBOUNCE_CYCLES have been seen and the next one still disagrees.
  always_comb begin
    level_next_s = level_r;
    count_next_s = 8'd0;
    if (sync2_r != level_r) begin
      if (count_r == DEB_LIMIT) begin
        level_next_s = sync2_r;
        count_next_s = 8'd0;
      end else begin
        level_next_s = level_r;
        count_next_s = count_r + 8'd1;
      end
    end else begin
      level_next_s = level_r;
      count_next_s = 8'd0;
    end
  end

  // Debounce counter; reset discards any partially accumulated count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_next_s;
    end
  end
`else
  // Without debounce the conditioned level is the synchronizer output one stage later.
  always_comb begin
    level_next_s = sync2_r;
  end
`endif

  // Press pulse is raised in the cycle before the level falls, so the request latches on that same edge.
  always_comb begin
    press = level_r & ~level_next_s;
  end

endmodule

// File: rtl/call_register.sv
// call_register: latches floor call requests from three active-low buttons,
// clears them when the car is stopped at that floor with the door open, and
// runs a small IDLE/UP/DOWN scheduler that names the next floor to serve.
// Optional debounce inside each button path: define CALL_REGISTER_DEBOUNCE_EN.
module call_register
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       door,
  input  logic       moving,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] target,
  output logic       dir_up,
  output logic       dir_down
);

  logic [NUM_FLOORS-1:0] buttons_s;
  logic [NUM_FLOORS-1:0] floors_s;
  logic [NUM_FLOORS-1:0] press_s;
  logic [NUM_FLOORS-1:0] clear_s;
  logic [NUM_FLOORS-1:0] req_next_s;
  logic [NUM_FLOORS-1:0] req_r;
  logic [NUM_FLOORS-1:0] above_req_s;
  logic [NUM_FLOORS-1:0] below_req_s;
  logic [1:0]            last_floor_r;
  dir_t                  state_r;
  dir_t                  state_next_s;
  logic [1:0]            target_r;
  logic [1:0]            target_next_s;
  logic                  dir_up_r;
  logic                  dir_up_next_s;
  logic                  dir_down_r;
  logic                  dir_down_next_s;

  assign buttons_s = {button3, button2, button1};
  assign floors_s  = {floor3, floor2, floor1};

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .button(buttons_s[i]),
      .press (press_s[i])
    );
  end

  // Request update: a press sets its bit, servicing clears it, and clear wins on a tie.
  always_comb begin
    clear_s    = floors_s & {NUM_FLOORS{door & ~moving}};
    req_next_s = (req_r | press_s) & ~clear_s;
  end

  // Request bits and last known floor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_r        <= 3'b000;
      last_floor_r <= 2'd1;
    end else begin
      req_r        <= req_next_s;
      last_floor_r <= decode_floor(floors_s, last_floor_r);
    end
  end

  assign led1 = req_r[0];
  assign led2 = req_r[1];
  assign led3 = req_r[2];

  // Scheduler state register together with its registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      target_r   <= FLOOR_NONE;
      dir_up_r   <= 1'b0;
      dir_down_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      target_r   <= target_next_s;
      dir_up_r   <= dir_up_next_s;
      dir_down_r <= dir_down_next_s;
    end
  end

  // Next direction: keep going while work remains ahead, otherwise turn or go idle.
  always_comb begin
    above_req_s  = req_r & above_mask(last_floor_r);
    below_req_s  = req_r & below_mask(last_floor_r);
    state_next_s = IDLE;
    case (state_r)
      IDLE, UP: begin
        if (|above_req_s) begin
          state_next_s = UP;
        end else if (|below_req_s) begin
          state_next_s = DOWN;
        end else begin
          state_next_s = IDLE;
        end
      end
      DOWN: begin
        if (|below_req_s) begin
          state_next_s = DOWN;
        end else if (|above_req_s) begin
          state_next_s = UP;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Target and direction flags for the state being entered.
  always_comb begin
    target_next_s   = FLOOR_NONE;
    dir_up_next_s   = 1'b0;
    dir_down_next_s = 1'b0;
    case (state_next_s)
      UP: begin
        target_next_s = lowest_floor(above_req_s);
        dir_up_next_s = 1'b1;
      end
      DOWN: begin
        target_next_s   = highest_floor(below_req_s);
        dir_down_next_s = 1'b1;
      end
      IDLE: begin
        if ((req_r & floor_bit(last_floor_r)) != 3'b000) begin
          target_next_s = last_floor_r;
        end else begin
          target_next_s = FLOOR_NONE;
        end
      end
      default: target_next_s = FLOOR_NONE;
    endcase
  end

  assign target   = target_r;
  assign dir_up   = dir_up_r;
  assign dir_down = dir_down_r;

endmodule
